// File: rtl/seg_window_display.sv
// -----------------------------------------------------------------------------
// seg_window_display
//
// Signed-result display engine for a multi-digit 7-segment panel.
// A load pulse captures a signed DATA_W-bit value. Its magnitude is converted
// to N_DIG BCD digits with an iterative double-dabble, one bit per clock.
// A scrollable window of N_AN-1 digits, plus a sign slot, is then
// time-multiplexed onto N_AN anodes.
//
// Parameters:
//   DATA_W      signed input width
//   N_DIG       BCD magnitude digits (must hold the decimal digits of 2^(DATA_W-1))
//   N_AN        anodes; slots 0..N_AN-2 show digits, slot N_AN-1 shows the sign
//   REFRESH_DIV clk_w cycles per anode scan step (>= 1)
//
// Ports:
//   clk_w    in   clock
//   rst_w    in   asynchronous, active-high reset
//   value_i  in   signed value to display
//   load_i   in   single-cycle pulse: capture value_i and start conversion
//   btnl_i   in   single-cycle pulse: scroll toward more significant digits
//   btnr_i   in   single-cycle pulse: scroll toward less significant digits
//   busy_o   out  conversion in progress
//   win_o    out  window position (index of the digit shown in slot 0)
//   seg_o    out  segments {a,b,c,d,e,f,g}, active-low, registered
//   an_o     out  anode enables, active-low one-hot, registered
//
// Optional build macro:
//   SEG_LEADING_ZERO_BLANK_EN  blanks digit slots above the most significant
//                              nonzero digit. Digit 0 always shows.
//
// Handshake: there is no valid/ready pair. load_i, btnl_i and btnr_i are
// single-cycle strobes sampled on each rising clk_w edge. A load_i seen
// while busy_o is high is dropped. busy_o is high for exactly DATA_W cycles,
// starting the edge after an accepted load_i.
// -----------------------------------------------------------------------------
module seg_window_display #(
  parameter int DATA_W      = 16,
  parameter int N_DIG       = 5,
  parameter int N_AN        = 4,
  parameter int REFRESH_DIV = 1,
  localparam int MAX_POS    = N_DIG - (N_AN - 1),
  localparam int WIN_W      = ($clog2(MAX_POS + 1) < 1) ? 1 : $clog2(MAX_POS + 1)
) (
  input  logic              clk_w,
  input  logic              rst_w,
  input  logic [DATA_W-1:0] value_i,
  input  logic              load_i,
  input  logic              btnl_i,
  input  logic              btnr_i,
  output logic              busy_o,
  output logic [WIN_W-1:0]  win_o,
  output logic [6:0]        seg_o,
  output logic [N_AN-1:0]   an_o
);

  localparam int BCD_W  = 4 * N_DIG;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SLOT_W = (N_AN > 1) ? $clog2(N_AN) : 1;

  localparam logic [DATA_W-1:0] MAG_ONE   = DATA_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
  localparam logic [WIN_W-1:0]  WIN_MAX   = WIN_W'(MAX_POS);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_AN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  // Conversion state
  state_t            state_q, state_d;
  logic              neg_q, neg_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]  sbcd_q, sbcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Displayed result
  logic [BCD_W-1:0]  dbcd_q, dbcd_d;
  logic              dsign_q, dsign_d;

  // Window and scan
  logic [WIN_W-1:0]  win_q, win_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [6:0]        seg_q, seg_d;
  logic [N_AN-1:0]   an_q, an_d;

  // Double-dabble datapath
  logic [BCD_W-1:0]  sbcd_adj;
  logic [BCD_W-1:0]  sbcd_shift;

  // Digit selection
  int                sel_idx;
  logic [3:0]        sel_dig;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  int                msd_idx;
`endif

  // Active-low {a,b,c,d,e,f,g} pattern for a decimal digit.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM: IDLE waits for load_i; CONV runs DATA_W double-dabble steps
  // ---------------------------------------------------------------------------
  always_comb begin
    // Add-3 correction on every nibble >= 5, then shift in the next mag bit.
    sbcd_adj = sbcd_q;
    for (int k = 0; k < N_DIG; k++) begin
      if (sbcd_q[4*k +: 4] >= 4'd5) begin
        sbcd_adj[4*k +: 4] = sbcd_q[4*k +: 4] + 4'd3;
      end
    end
    sbcd_shift = {sbcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
  end

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    sbcd_d  = sbcd_q;
    cnt_d   = cnt_q;
    dbcd_d  = dbcd_q;
    dsign_d = dsign_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          neg_d = value_i[DATA_W-1];
          // The most negative input negates to itself, which read as unsigned
          // is exactly its magnitude, so no extra bit is needed.
          mag_d   = value_i[DATA_W-1] ? ((~value_i) + MAG_ONE) : value_i;
          sbcd_d  = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sbcd_d = sbcd_shift;
        mag_d  = {mag_q[DATA_W-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // The last shift goes straight to the display, so the new value
          // appears on the same edge that returns the FSM to IDLE.
          dbcd_d  = sbcd_shift;
          dsign_d = neg_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window position: each button steps one digit and saturates; pressing both
  // together cancels out.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_d = win_q;
    if (btnl_i && !btnr_i && (win_q != WIN_MAX)) begin
      win_d = win_q + WIN_ONE;
    end else if (btnr_i && !btnl_i && (win_q != '0)) begin
      win_d = win_q - WIN_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan divider and slot counter
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d  = div_q + DIV_ONE;
    slot_d = slot_q;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : (slot_q + SLOT_ONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Output pattern for the current slot. Outputs are registered, so the panel
  // sees the pattern for slot_q one cycle after slot_q takes that value.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_idx = int'(win_q) + int'(slot_q);
    sel_dig = '0;
    for (int d = 0; d < N_DIG; d++) begin
      if (d == sel_idx) begin
        sel_dig = dbcd_q[4*d +: 4];
      end
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Highest nonzero digit; stays 0 for a zero value so digit 0 still shows.
    msd_idx = 0;
    for (int d = 0; d < N_DIG; d++) begin
      if (dbcd_q[4*d +: 4] != 4'd0) begin
        msd_idx = d;
      end
    end
`endif

    an_d         = '1;
    an_d[slot_q] = 1'b0;

    if (slot_q == SLOT_LAST) begin
      seg_d = dsign_q ? 7'b1111110 : 7'b1111111;
    end else begin
      seg_d = digit_to_seg(sel_dig);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (sel_idx > msd_idx) begin
        seg_d = 7'b1111111;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      state_q <= S_IDLE;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      sbcd_q  <= '0;
      cnt_q   <= '0;
      dbcd_q  <= '0;
      dsign_q <= 1'b0;
      win_q   <= '0;
      div_q   <= '0;
      slot_q  <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      sbcd_q  <= sbcd_d;
      cnt_q   <= cnt_d;
      dbcd_q  <= dbcd_d;
      dsign_q <= dsign_d;
      win_q   <= win_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy_o = (state_q == S_CONV);
  assign win_o  = win_q;
  assign seg_o  = seg_q;
  assign an_o   = an_q;

endmodule

// File: tb/tb_seg_window_display.sv
// -----------------------------------------------------------------------------
// tb_seg_window_display
//
// Self-checking bench for seg_window_display with default parameters.
// The reference model keeps only the displayed signed value and the window
// position. Expected segment patterns are derived with decimal arithmetic on
// that value. Honours SEG_LEADING_ZERO_BLANK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_seg_window_display;

  localparam int DATA_W      = 16;
  localparam int N_DIG       = 5;
  localparam int N_AN        = 4;
  localparam int REFRESH_DIV = 1;
  localparam int MAX_POS     = N_DIG - (N_AN - 1);
  localparam int WIN_W       = ($clog2(MAX_POS + 1) < 1) ? 1 : $clog2(MAX_POS + 1);

  // Clock and reset
  logic              clk_w;
  logic              rst_w;
  logic [DATA_W-1:0] value_i;
  logic              load_i;
  logic              btnl_i;
  logic              btnr_i;
  logic              busy_o;
  logic [WIN_W-1:0]  win_o;
  logic [6:0]        seg_o;
  logic [N_AN-1:0]   an_o;

  int n_checks;
  int n_fail;

  // Reference model state
  int exp_val;
  int exp_win;

  // Captured panel state
  logic [6:0] got_seg[N_AN];
  logic       seen[N_AN];
  logic       scan_ok;

  seg_window_display #(
    .DATA_W(DATA_W),
    .N_DIG(N_DIG),
    .N_AN(N_AN),
    .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk_w(clk_w),
    .rst_w(rst_w),
    .value_i(value_i),
    .load_i(load_i),
    .btnl_i(btnl_i),
    .btnr_i(btnr_i),
    .busy_o(busy_o),
    .win_o(win_o),
    .seg_o(seg_o),
    .an_o(an_o)
  );

  initial begin
    clk_w = 1'b0;
    forever #5 clk_w = ~clk_w;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int ndigits(input longint m);
    int n;
    n = 1;
    while (m >= 10) begin
      m = m / 10;
      n++;
    end
    return n;
  endfunction

  function automatic logic [6:0] exp_seg(input int slot);
    longint m;
    longint p;
    int     idx;
    if (slot == N_AN - 1) return (exp_val < 0) ? 7'b1111110 : 7'b1111111;
    idx = exp_win + slot;
    m   = (exp_val < 0) ? -longint'(exp_val) : longint'(exp_val);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (idx >= ndigits(m)) return 7'b1111111;
`endif
    p = 1;
    repeat (idx) p = p * 10;
    return seg7(int'((m / p) % 10));
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Pulse load_i, then count the cycles busy_o stays high (bounded).
  task automatic drive_load(input logic [DATA_W-1:0] v, output int bc);
    @(negedge clk_w);
    value_i = v;
    load_i  = 1'b1;
    @(negedge clk_w);
    load_i  = 1'b0;
    value_i = DATA_W'($urandom);
    bc = 0;
    while (busy_o === 1'b1 && bc < 200) begin
      bc++;
      @(negedge clk_w);
    end
  endtask

  task automatic press(input logic l, input logic r);
    @(negedge clk_w);
    btnl_i = l;
    btnr_i = r;
    @(negedge clk_w);
    btnl_i = 1'b0;
    btnr_i = 1'b0;
    if (l && !r && exp_win < MAX_POS) exp_win++;
    else if (r && !l && exp_win > 0) exp_win--;
  endtask

  // Watch two full scans, recording the pattern shown on each anode and
  // whether the anodes rotate 0,1,..,N_AN-1 in order.
  task automatic capture_slots();
    int prev;
    int sl;
    logic [N_AN-1:0] pat;
    prev    = -1;
    scan_ok = 1'b1;
    for (int s = 0; s < N_AN; s++) begin
      seen[s]    = 1'b0;
      got_seg[s] = 7'bxxxxxxx;
    end
    for (int i = 0; i < 2 * N_AN * REFRESH_DIV; i++) begin
      @(negedge clk_w);
      sl = -1;
      for (int s = 0; s < N_AN; s++) begin
        pat    = '1;
        pat[s] = 1'b0;
        if (an_o === pat) sl = s;
      end
      if (sl < 0) begin
        scan_ok = 1'b0;
      end else begin
        if (prev >= 0 && sl != (prev + 1) % N_AN) scan_ok = 1'b0;
        prev        = sl;
        seen[sl]    = 1'b1;
        got_seg[sl] = seg_o;
      end
    end
    for (int s = 0; s < N_AN; s++) if (!seen[s]) scan_ok = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_w = 1'b1;
    repeat (3) @(negedge clk_w);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy_o); end
    n_checks++;
    if (win_o !== '0) begin n_fail++; $display("FAIL reset win: got %0d expected 0", win_o); end
    n_checks++;
    if (an_o !== '1) begin n_fail++; $display("FAIL reset an: got %b expected all ones", an_o); end
    n_checks++;
    if (seg_o !== 7'b1111111) begin n_fail++; $display("FAIL reset seg: got %b expected 1111111", seg_o); end
    rst_w = 1'b0;
    exp_val = 0;
    exp_win = 0;
    capture_slots();
    for (int s = 0; s < N_AN; s++) begin
      n_checks++;
      if (got_seg[s] !== exp_seg(s)) begin
        n_fail++; $display("FAIL reset slot%0d: got %b expected %b", s, got_seg[s], exp_seg(s));
      end
    end
  endtask

  task automatic test_zero();
    int bc;
    drive_load(16'h0000, bc);
    n_checks++;
    if (bc != DATA_W) begin n_fail++; $display("FAIL zero busy cycles: got %0d expected %0d", bc, DATA_W); end
    exp_val = 0;
    capture_slots();
    n_checks++;
    if (scan_ok !== 1'b1) begin n_fail++; $display("FAIL zero anode scan: got %b expected 1", scan_ok); end
    for (int s = 0; s < N_AN; s++) begin
      n_checks++;
      if (got_seg[s] !== exp_seg(s)) begin
        n_fail++; $display("FAIL zero slot%0d: got %b expected %b", s, got_seg[s], exp_seg(s));
      end
    end
  endtask

  task automatic test_scroll();
    int bc;
    drive_load(16'hCFC7, bc);
    n_checks++;
    if (bc != DATA_W) begin n_fail++; $display("FAIL scroll busy cycles: got %0d expected %0d", bc, DATA_W); end
    exp_val = -12345;
    for (int step = 0; step < 4; step++) begin
      if (step == 1) press(1'b1, 1'b0);
      if (step == 2) begin press(1'b1, 1'b0); press(1'b1, 1'b0); end
      if (step == 3) begin press(1'b0, 1'b1); press(1'b0, 1'b1); press(1'b0, 1'b1); end
      n_checks++;
      if (win_o !== WIN_W'(exp_win)) begin
        n_fail++; $display("FAIL scroll win step%0d: got %0d expected %0d", step, win_o, exp_win);
      end
      capture_slots();
      for (int s = 0; s < N_AN; s++) begin
        n_checks++;
        if (got_seg[s] !== exp_seg(s)) begin
          n_fail++; $display("FAIL scroll step%0d slot%0d: got %b expected %b", step, s, got_seg[s], exp_seg(s));
        end
      end
    end
  endtask

  task automatic test_min_value();
    int bc;
    drive_load(16'h8000, bc);
    n_checks++;
    if (bc != DATA_W) begin n_fail++; $display("FAIL min busy cycles: got %0d expected %0d", bc, DATA_W); end
    exp_val = -32768;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    n_checks++;
    if (win_o !== WIN_W'(2)) begin n_fail++; $display("FAIL min win: got %0d expected 2", win_o); end
    capture_slots();
    for (int s = 0; s < N_AN; s++) begin
      n_checks++;
      if (got_seg[s] !== exp_seg(s)) begin
        n_fail++; $display("FAIL min slot%0d: got %b expected %b", s, got_seg[s], exp_seg(s));
      end
    end
    n_checks++;
    if (got_seg[0] !== 7'b0001111) begin n_fail++; $display("FAIL min slot0 digit7: got %b expected 0001111", got_seg[0]); end
  endtask

  task automatic test_ignore_and_buttons();
    int bc;
    // Second load pulse lands on the fifth busy cycle and must be dropped.
    @(negedge clk_w);
    value_i = 16'd12345;
    load_i  = 1'b1;
    @(negedge clk_w);
    load_i = 1'b0;
    bc = 0;
    while (busy_o === 1'b1 && bc < 200) begin
      bc++;
      if (bc == 5) begin value_i = 16'd999; load_i = 1'b1; end
      else load_i = 1'b0;
      @(negedge clk_w);
    end
    load_i = 1'b0;
    n_checks++;
    if (bc != DATA_W) begin n_fail++; $display("FAIL ignore busy cycles: got %0d expected %0d", bc, DATA_W); end
    @(negedge clk_w);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ignore no restart: got busy %b expected 0", busy_o); end
    exp_val = 12345;
    capture_slots();
    for (int s = 0; s < N_AN; s++) begin
      n_checks++;
      if (got_seg[s] !== exp_seg(s)) begin
        n_fail++; $display("FAIL ignore slot%0d: got %b expected %b", s, got_seg[s], exp_seg(s));
      end
    end
    // Window: both buttons together, and btnr at zero.
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    n_checks++;
    if (win_o !== WIN_W'(1)) begin n_fail++; $display("FAIL both buttons at 1: got %0d expected 1", win_o); end
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    n_checks++;
    if (win_o !== WIN_W'(0)) begin n_fail++; $display("FAIL both buttons at 0: got %0d expected 0", win_o); end
    press(1'b0, 1'b1);
    n_checks++;
    if (win_o !== WIN_W'(0)) begin n_fail++; $display("FAIL btnr saturate: got %0d expected 0", win_o); end
  endtask

  task automatic test_reset_mid_conversion();
    int bc;
    press(1'b1, 1'b0);
    @(negedge clk_w);
    value_i = 16'hCFC7;
    load_i  = 1'b1;
    @(negedge clk_w);
    load_i = 1'b0;
    bc = 0;
    while (busy_o === 1'b1 && bc < 7) begin
      bc++;
      @(negedge clk_w);
    end
    // Assert reset away from any clock edge and check it acts at once.
    #2 rst_w = 1'b1;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b expected 0", busy_o); end
    n_checks++;
    if (an_o !== '1) begin n_fail++; $display("FAIL midreset an: got %b expected all ones", an_o); end
    n_checks++;
    if (seg_o !== 7'b1111111) begin n_fail++; $display("FAIL midreset seg: got %b expected 1111111", seg_o); end
    n_checks++;
    if (win_o !== '0) begin n_fail++; $display("FAIL midreset win: got %0d expected 0", win_o); end
    @(negedge clk_w);
    rst_w   = 1'b0;
    exp_val = 0;
    exp_win = 0;
    capture_slots();
    for (int s = 0; s < N_AN; s++) begin
      n_checks++;
      if (got_seg[s] !== exp_seg(s)) begin
        n_fail++; $display("FAIL midreset slot%0d: got %b expected %b", s, got_seg[s], exp_seg(s));
      end
    end
  endtask

  task automatic test_blank();
    int bc;
    drive_load(16'd42, bc);
    exp_val = 42;
    capture_slots();
    n_checks++;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (got_seg[2] !== 7'b1111111) begin n_fail++; $display("FAIL blank 42 slot2: got %b expected 1111111", got_seg[2]); end
`else
    if (got_seg[2] !== 7'b0000001) begin n_fail++; $display("FAIL blank 42 slot2: got %b expected 0000001", got_seg[2]); end
`endif
    for (int s = 0; s < N_AN; s++) begin
      n_checks++;
      if (got_seg[s] !== exp_seg(s)) begin
        n_fail++; $display("FAIL blank 42 slot%0d: got %b expected %b", s, got_seg[s], exp_seg(s));
      end
    end
    drive_load(16'd0, bc);
    exp_val = 0;
    capture_slots();
    n_checks++;
    if (got_seg[0] !== 7'b0000001) begin n_fail++; $display("FAIL blank zero slot0: got %b expected 0000001", got_seg[0]); end
    for (int s = 1; s < N_AN; s++) begin
      n_checks++;
      if (got_seg[s] !== exp_seg(s)) begin
        n_fail++; $display("FAIL blank zero slot%0d: got %b expected %b", s, got_seg[s], exp_seg(s));
      end
    end
  endtask

  task automatic test_random();
    int bc;
    int np;
    logic [DATA_W-1:0] v;
    for (int it = 0; it < 24; it++) begin
      case (it)
        0:       v = 16'h7FFF;
        1:       v = 16'hFFFF;
        2:       v = 16'h8001;
        default: v = DATA_W'($urandom);
      endcase
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive_load(v, bc);
      exp_val = int'($signed(v));
      n_checks++;
      if (bc != DATA_W) begin n_fail++; $display("FAIL random%0d busy cycles: got %0d expected %0d", it, bc, DATA_W); end
      n_checks++;
      if (win_o !== WIN_W'(exp_win)) begin n_fail++; $display("FAIL random%0d win: got %0d expected %0d", it, win_o, exp_win); end
      capture_slots();
      for (int s = 0; s < N_AN; s++) begin
        n_checks++;
        if (got_seg[s] !== exp_seg(s)) begin
          n_fail++;
          $display("FAIL random%0d value %0d win %0d slot%0d: got %b expected %b", it, exp_val, exp_win, s, got_seg[s], exp_seg(s));
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_val  = 0;
    exp_win  = 0;
    rst_w    = 1'b1;
    value_i  = '0;
    load_i   = 1'b0;
    btnl_i   = 1'b0;
    btnr_i   = 1'b0;
    test_reset();
    test_zero();
    test_scroll();
    test_min_value();
    test_ignore_and_buttons();
    test_reset_mid_conversion();
    test_blank();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
